// File: rtl/servo_duty_ramp.sv
// Push-button front end for the servo controller: synchronises and debounces three
// active-low keys, then ramps an 8-bit duty command with saturation and auto-repeat.
module servo_duty_ramp #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 2500000,
  parameter int STEP            = 1,
  parameter int DUTY_MIN        = 0,
  parameter int DUTY_MAX        = 255,
  parameter int DUTY_INIT       = 128
) (
  input  logic       Main_clock,
  input  logic       reset,
  input  logic       key_up_n,
  input  logic       key_down_n,
  input  logic       key_center_n,
  output logic [7:0] duty_cycle,
  output logic       duty_update,
  output logic       at_limit
);

  localparam int NK   = 3;
  localparam int K_UP = 0;
  localparam int K_DN = 1;
  localparam int K_CT = 2;

  localparam logic [31:0] DB_LAST = 32'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] RD_LAST = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0] RR_LAST = 32'(REPEAT_RATE - 1);

  localparam logic [8:0] STEP9 = 9'(STEP);
  localparam logic [8:0] MIN9  = 9'(DUTY_MIN);
  localparam logic [8:0] MAX9  = 9'(DUTY_MAX);
  localparam logic [7:0] MIN8  = 8'(DUTY_MIN);
  localparam logic [7:0] MAX8  = 8'(DUTY_MAX);
  localparam logic [7:0] INIT8 = 8'(DUTY_INIT);
  localparam logic       LIM_INIT = (DUTY_INIT == DUTY_MIN) || (DUTY_INIT == DUTY_MAX);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  logic [NK-1:0]       key_raw;
  logic [NK-1:0]       sync1_q, sync1_d, sync2_q, sync2_d;
  logic [NK-1:0]       deb_q, deb_d, deb_prev_q, deb_prev_d;
  logic [NK-1:0][31:0] db_cnt_q, db_cnt_d;
  logic [NK-1:0]       held, press;

  logic [1:0]  state_q, state_d;
  logic        dir_up_q, dir_up_d;
  logic [31:0] rcnt_q, rcnt_d;
  logic [7:0]  duty_q, duty_d;
  logic        upd_q, upd_d;
  logic        lim_q, lim_d;

  logic [8:0]  up_sum, dn_diff;
  logic [7:0]  up_val, dn_val;
  logic        do_step, step_up, active_held;

  assign key_raw = {key_center_n, key_down_n, key_up_n};

  // Debounced level is 1 when released; a key must disagree with it for
  // DEBOUNCE_CYCLES consecutive cycles before the level follows.
  always_comb begin
    sync1_d    = key_raw;
    sync2_d    = sync1_q;
    deb_prev_d = deb_q;
    deb_d      = deb_q;
    db_cnt_d   = '0;
    for (int k = 0; k < NK; k++) begin
      if (sync2_q[k] != deb_q[k]) begin
        if (db_cnt_q[k] == DB_LAST) deb_d[k] = ~deb_q[k];
        else                        db_cnt_d[k] = db_cnt_q[k] + 32'd1;
      end
    end
  end

  assign held  = ~deb_q;
  assign press = deb_prev_q & ~deb_q;

  // Borrow out of the 9-bit subtract means the step would go below zero.
  assign up_sum  = {1'b0, duty_q} + STEP9;
  assign dn_diff = {1'b0, duty_q} - STEP9;
  assign up_val  = (up_sum > MAX9) ? MAX8 : up_sum[7:0];
  assign dn_val  = (dn_diff[8] || (dn_diff < MIN9)) ? MIN8 : dn_diff[7:0];

  assign active_held = dir_up_q ? held[K_UP] : held[K_DN];

  always_comb begin
    state_d  = state_q;
    dir_up_d = dir_up_q;
    rcnt_d   = rcnt_q;
    duty_d   = duty_q;
    do_step  = 1'b0;
    step_up  = dir_up_q;
    if (press[K_CT]) begin
      duty_d  = INIT8;
      state_d = ST_IDLE;
      rcnt_d  = '0;
    end else if (held[K_CT] || (held[K_UP] && held[K_DN])) begin
      state_d = ST_IDLE;
      rcnt_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (press[K_UP] || press[K_DN]) begin
            do_step  = 1'b1;
            step_up  = press[K_UP];
            dir_up_d = press[K_UP];
            state_d  = ST_DELAY;
            rcnt_d   = '0;
          end
        end
        ST_DELAY, ST_REPEAT: begin
          if (!active_held) begin
            state_d = ST_IDLE;
            rcnt_d  = '0;
          end else if (rcnt_q == ((state_q == ST_DELAY) ? RD_LAST : RR_LAST)) begin
            do_step = 1'b1;
            state_d = ST_REPEAT;
            rcnt_d  = '0;
          end else begin
            rcnt_d = rcnt_q + 32'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          rcnt_d  = '0;
        end
      endcase
    end
    if (do_step) duty_d = step_up ? up_val : dn_val;
    upd_d = (duty_d != duty_q);
    lim_d = (duty_d == MIN8) || (duty_d == MAX8);
  end

  always_ff @(posedge Main_clock or negedge reset) begin
    if (!reset) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      deb_q      <= '1;
      deb_prev_q <= '1;
      db_cnt_q   <= '0;
      state_q    <= ST_IDLE;
      dir_up_q   <= 1'b0;
      rcnt_q     <= '0;
      duty_q     <= INIT8;
      upd_q      <= 1'b0;
      lim_q      <= LIM_INIT;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      db_cnt_q   <= db_cnt_d;
      state_q    <= state_d;
      dir_up_q   <= dir_up_d;
      rcnt_q     <= rcnt_d;
      duty_q     <= duty_d;
      upd_q      <= upd_d;
      lim_q      <= lim_d;
    end
  end

  assign duty_cycle  = duty_q;
  assign duty_update = upd_q;
  assign at_limit    = lim_q;

endmodule

// File: tb/tb_servo_duty_ramp.sv
// Bench for servo_duty_ramp: stimulus table, directed timing/reset/saturation
// sequences, and random key activity compared against a cycle-level reference model.
module tb_servo_duty_ramp;
  localparam int D   = 4;
  localparam int RD  = 20;
  localparam int RR  = 5;
  localparam int ST  = 1;
  localparam int MN  = 0;
  localparam int MX  = 255;
  localparam int INI = 128;

  logic       Main_clock = 1'b0;
  logic       reset = 1'b0;
  logic       key_up_n = 1'b1, key_down_n = 1'b1, key_center_n = 1'b1, key_up2_n = 1'b1;
  logic [7:0] duty_cycle, duty2;
  logic       duty_update, at_limit, upd2, lim2;

  always #5 Main_clock = ~Main_clock;

  servo_duty_ramp #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_RATE(RR),
                    .STEP(ST), .DUTY_MIN(MN), .DUTY_MAX(MX), .DUTY_INIT(INI)) dut (
    .Main_clock(Main_clock), .reset(reset), .key_up_n(key_up_n), .key_down_n(key_down_n),
    .key_center_n(key_center_n), .duty_cycle(duty_cycle), .duty_update(duty_update),
    .at_limit(at_limit));

  servo_duty_ramp #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_RATE(RR),
                    .STEP(4), .DUTY_MIN(0), .DUTY_MAX(255), .DUTY_INIT(254)) dut_sat (
    .Main_clock(Main_clock), .reset(reset), .key_up_n(key_up2_n), .key_down_n(1'b1),
    .key_center_n(1'b1), .duty_cycle(duty2), .duty_update(upd2), .at_limit(lim2));

  int n_chk = 0, n_pass = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d at %0t", nm, act, exp, $time);
  endtask

  // Reference model: per-cycle rules stated directly in terms of sample history
  // and elapsed time since the first step of a hold.
  bit sh[3][8];
  bit lev[3], lev_p[3];
  int m_duty, m_mode, m_t;
  bit m_upd, m_lim;
  bit chk_en = 1'b0;

  function automatic int mstep(input int d, input bit up);
    if (up) return (d + ST > MX) ? MX : d + ST;
    return (d - ST < MN) ? MN : d - ST;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 8; j++) sh[k][j] = 1'b1;
      lev[k] = 1'b1; lev_p[k] = 1'b1;
    end
    m_duty = INI; m_upd = 1'b0; m_lim = (INI == MN) || (INI == MX);
    m_mode = 0; m_t = 0;
  endtask

  task automatic model_edge();
    bit pr[3], hd[3], raw[3];
    bit flip, act;
    int old;
    raw[0] = key_up_n; raw[1] = key_down_n; raw[2] = key_center_n;
    for (int k = 0; k < 3; k++) begin
      hd[k] = !lev[k];
      pr[k] = lev_p[k] && !lev[k];
    end
    old = m_duty;
    act = (m_mode == 1) ? hd[0] : hd[1];
    if (pr[2]) begin
      m_duty = INI; m_mode = 0;
    end else if (hd[2] || (hd[0] && hd[1])) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      if (pr[0] || pr[1]) begin
        m_mode = pr[0] ? 1 : 2; m_t = 0; m_duty = mstep(m_duty, pr[0]);
      end
    end else if (!act) begin
      m_mode = 0;
    end else begin
      m_t++;
      if (m_t == RD || (m_t > RD && (m_t - RD) % RR == 0)) m_duty = mstep(m_duty, m_mode == 1);
    end
    m_upd = (m_duty != old);
    m_lim = (m_duty == MN) || (m_duty == MX);
    // level flips once the D synchronised samples (raw delayed by two edges) all disagree
    for (int k = 0; k < 3; k++) begin
      for (int j = 7; j > 0; j--) sh[k][j] = sh[k][j-1];
      sh[k][0] = raw[k];
      lev_p[k] = lev[k];
      flip = 1'b1;
      for (int j = 2; j < D + 2; j++) if (sh[k][j] == lev[k]) flip = 1'b0;
      if (flip) lev[k] = !lev[k];
    end
  endtask

  always @(posedge Main_clock or negedge reset) begin
    if (!reset) model_reset();
    else        model_edge();
  end

  always @(negedge Main_clock) begin
    if (chk_en) begin
      check("mon_duty", int'(duty_cycle), m_duty);
      check("mon_upd", int'(duty_update), int'(m_upd));
      check("mon_lim", int'(at_limit), int'(m_lim));
    end
  end

  typedef struct {
    bit up, dn, ct;
    int cyc;
    int exp_duty;
    int exp_pulses;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit up, input bit dn, input bit ct, input int cyc,
                     input int ed, input int ep);
    vec_t v;
    v.up = up; v.dn = dn; v.ct = ct; v.cyc = cyc; v.exp_duty = ed; v.exp_pulses = ep;
    tbl.push_back(v);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Main_clock);
  endtask

  int d_log[1:40], u_log[1:40];
  int p, n;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    // bounce, single press, release
    add(0,1,1, 2,128,0); add(1,1,1, 2,128,0); add(0,1,1, 2,128,0);
    add(1,1,1, 2,128,0); add(0,1,1, 2,128,0); add(1,1,1, 2,128,0);
    add(0,1,1,10,129,1); add(1,1,1,10,129,0);
    // down auto-repeat, with one last step before the debounced release
    add(1,0,1,57,121,8); add(1,1,1,10,120,1);
    // simultaneous press
    add(0,0,1,10,120,0); add(1,1,1,10,120,0);
    // down pressed while up repeats
    add(0,1,1,30,122,2); add(0,0,1,10,123,1); add(0,0,1,30,123,0);
    add(0,1,1,30,123,0); add(1,1,1,10,123,0);
    // ramp to 140, then centre while up is held
    add(0,1,1,100,139,16); add(0,1,0,10,128,2); add(0,1,0,30,128,0);
    add(0,1,1,30,128,0); add(1,1,1,10,128,0);

    reset = 1'b0;
    idle(3);
    chk_en = 1'b1;
    check("rst_duty", int'(duty_cycle), 128);
    check("rst_upd", int'(duty_update), 0);
    check("rst_lim", int'(at_limit), 0);
    check("rst2_duty", int'(duty2), 254);
    check("rst2_lim", int'(lim2), 0);
    reset = 1'b1;
    idle(10);

    foreach (tbl[i]) begin
      key_up_n = tbl[i].up; key_down_n = tbl[i].dn; key_center_n = tbl[i].ct;
      p = 0;
      repeat (tbl[i].cyc) begin
        @(negedge Main_clock);
        p += int'(duty_update);
      end
      check($sformatf("vec%0d_duty", i), int'(duty_cycle), tbl[i].exp_duty);
      check($sformatf("vec%0d_pulses", i), p, tbl[i].exp_pulses);
    end

    // press latency and first repeat spacing
    key_up_n = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge Main_clock);
      d_log[i] = int'(duty_cycle); u_log[i] = int'(duty_update);
    end
    check("lat_before", d_log[6], 128);
    check("lat_step", d_log[7], 129);
    check("lat_pulse", u_log[7], 1);
    check("lat_pulse_end", u_log[8], 0);
    check("rep_before", d_log[26], 129);
    check("rep_first", d_log[27], 130);
    check("rep_pulse", u_log[27], 1);
    key_up_n = 1'b1;
    idle(15);

    // asynchronous reset in the middle of a down repeat, key kept held
    key_down_n = 1'b0;
    idle(30);
    #2 reset = 1'b0;
    #1;
    check("arst_duty", int'(duty_cycle), 128);
    check("arst_upd", int'(duty_update), 0);
    check("arst_lim", int'(at_limit), 0);
    idle(2);
    reset = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge Main_clock);
      d_log[i] = int'(duty_cycle); u_log[i] = int'(duty_update);
    end
    check("rel_hold", d_log[6], 128);
    check("rel_step", d_log[7], 127);
    check("rel_pulse", u_log[7], 1);
    key_down_n = 1'b1;
    idle(15);

    // saturation at the top bound on the STEP=4, INIT=254 instance
    key_up2_n = 1'b0; p = 0;
    repeat (10) begin
      @(negedge Main_clock);
      if (upd2) begin
        p++;
        check("sat_lim_with_step", int'(lim2), 1);
      end
    end
    check("sat1_duty", int'(duty2), 255);
    check("sat1_pulses", p, 1);
    check("sat1_lim", int'(lim2), 1);
    key_up2_n = 1'b1;
    idle(10);
    key_up2_n = 1'b0; p = 0;
    repeat (10) begin
      @(negedge Main_clock);
      p += int'(upd2);
    end
    check("sat2_duty", int'(duty2), 255);
    check("sat2_pulses", p, 0);
    check("sat2_lim", int'(lim2), 1);
    key_up2_n = 1'b1;
    idle(10);

    // random key activity, checked every cycle by the model
    for (int s = 0; s < 300; s++) begin
      key_up_n     = ($urandom_range(0, 1) != 0);
      key_down_n   = ($urandom_range(0, 2) != 0);
      key_center_n = ($urandom_range(0, 11) != 0);
      n = ($urandom_range(0, 5) == 0) ? int'($urandom_range(20, 60)) : int'($urandom_range(1, 12));
      idle(n);
    end
    key_up_n = 1'b1; key_down_n = 1'b1; key_center_n = 1'b1;
    idle(20);
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
